// File: rtl/mgt_01_div_scheduler_pkg.sv
// Shared types and constants for the divide-unit issue/retire scheduler.
package mgt_01_div_scheduler_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DIV_LATENCY = 36;
  localparam int unsigned DIV_TAG_W   = 5;

  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;

  typedef struct packed {
    logic                 valid;
    div_ops_e             ops;
    logic [DIV_TAG_W-1:0] tag;
  } div_tag_s;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } div_sched_state_e;

endpackage

// File: rtl/mgt_01_div_scheduler_div_tag_pipe.sv
// Enable-gated shift register of op tags, kept in lockstep with the divider pipeline.
module div_tag_pipe
  import mgt_01_div_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = DIV_LATENCY
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     en_i,
  input  logic     clr_i,
  input  div_tag_s in_i,
  output div_tag_s tail_o
);

  div_tag_s [DEPTH-1:0] pipe_q;
  div_tag_s [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (clr_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_d[i].valid = 1'b0;
      end
    end else if (en_i) begin
      pipe_d[0] = in_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mgt_01_div_scheduler.sv
// Issue/retire controller for the pipelined divider: tags in-flight ops, selects
// the divider output at retirement and freezes the divider on response back-pressure.
module mgt_01_div_scheduler
  import mgt_01_div_scheduler_pkg::*;
#(
  parameter int unsigned LATENCY      = DIV_LATENCY,
  parameter int unsigned TAG_W        = DIV_TAG_W,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  div_ops_e         req_ops_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic [XLEN-1:0]  req_dividend_i,
  input  logic [XLEN-1:0]  req_divisor_i,
  input  logic             flush_i,
  output logic             div_clk_en_o,
  output logic [XLEN-1:0]  div_dividend_o,
  output logic [XLEN-1:0]  div_divisor_o,
  output div_ops_e         div_ops_o,
  input  logic [XLEN-1:0]  div_result_i,
  input  logic             div_by_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [XLEN-1:0]  rsp_result_o,
  output logic             rsp_div_by_zero_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  div_tag_s         stage_in;
  div_tag_s         tail;
  logic             accept;
  logic             retire;
  logic [CNT_W-1:0] count_q, count_d;
  div_ops_e         ops_q, ops_d;
  div_sched_state_e state_q, state_d;

  always_comb begin
    div_clk_en_o = ~(tail.valid & ~rsp_ready_i) | flush_i;
    rsp_valid_o  = tail.valid & ~flush_i;
    retire       = rsp_valid_o & rsp_ready_i;
    req_ready_o  = div_clk_en_o & ~flush_i & ((count_q < MAX_CNT) | retire);
    accept       = req_valid_i & req_ready_o;

    stage_in.valid = accept;
    stage_in.ops   = req_ops_i;
    stage_in.tag   = DIV_TAG_W'(req_tag_i);

    div_dividend_o = req_dividend_i;
    div_divisor_o  = req_divisor_i;

    ops_d             = tail.valid ? tail.ops : ops_q;
    div_ops_o         = ops_d;
    rsp_tag_o         = TAG_W'(tail.tag);
    rsp_result_o      = div_result_i;
    rsp_div_by_zero_o = div_by_zero_i & rsp_valid_o;

    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(retire);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (tail.valid & ~rsp_ready_i) state_d = STALL;
        else if (count_d == '0)        state_d = IDLE;
      end
      // Retiring the last op out of a stall returns straight to IDLE so busy tracks the count.
      STALL:   if (rsp_ready_i) state_d = (count_d == '0) ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
    busy_o = (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      ops_q   <= DIV_;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      ops_q   <= ops_d;
      state_q <= state_d;
    end
  end

  div_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (div_clk_en_o),
    .clr_i   (flush_i),
    .in_i    (stage_in),
    .tail_o  (tail)
  );

endmodule
